// File: rtl/cpu_pipeline_ctrl_if.sv
// Pipeline controller bundle: stage stall/busy inputs, MEM events,
// control-register read port, IRQ lines, stall/flush/redirect outputs.
interface cpu_pipeline_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 30,
  parameter int IRQ_W  = 8
);
  logic              IFBusy;
  logic              MemBusy;
  logic              LDHazard;
  logic              MEMEn;
  logic [ADDR_W-1:0] MEMPC;
  logic [2:0]        MEMExpCode;
  logic [1:0]        MEMCtrlOp;
  logic [4:0]        MEMDstAddr;
  logic [WORD_W-1:0] MEMWrData;
  logic [4:0]        CRegRdAddr;
  logic [WORD_W-1:0] CRegRdData;
  logic              ExeMode;
  logic [IRQ_W-1:0]  IRQ;
  logic              IFStall;
  logic              IDStall;
  logic              EXStall;
  logic              MEMStall;
  logic              IFFlush;
  logic              IDFlush;
  logic              EXFlush;
  logic              MEMFlush;
  logic [ADDR_W-1:0] NewPC;

  modport master (
    output IFBusy, MemBusy, LDHazard, MEMEn,
    output MEMPC, MEMExpCode, MEMCtrlOp,
    output MEMDstAddr, MEMWrData,
    output CRegRdAddr, IRQ,
    input  CRegRdData, ExeMode,
    input  IFStall, IDStall, EXStall, MEMStall,
    input  IFFlush, IDFlush, EXFlush, MEMFlush,
    input  NewPC
  );

  modport slave (
    input  IFBusy, MemBusy, LDHazard, MEMEn,
    input  MEMPC, MEMExpCode, MEMCtrlOp,
    input  MEMDstAddr, MEMWrData,
    input  CRegRdAddr, IRQ,
    output CRegRdData, ExeMode,
    output IFStall, IDStall, EXStall, MEMStall,
    output IFFlush, IDFlush, EXFlush, MEMFlush,
    output NewPC
  );
endinterface

// File: rtl/cpu_pipeline_ctrl.sv
// Pipeline controller: stall/flush generation, trap/EXRT redirect and
// control-register file. Ports: clk, reset (async, active high) and the
// cpu_pipeline_ctrl_if slave bundle. Optional macro CPU_CTRL_IRQ_EN adds
// the IRQ synchroniser, CR5 IRQ_MASK, CR6 IRQ_PEND and interrupt takes.
module cpu_pipeline_ctrl #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 30,
  parameter int IRQ_W  = 8
) (
  input  logic clk,
  input  logic reset,
  cpu_pipeline_ctrl_if.slave bus
);
  typedef enum logic {RUN, REDIR} state_e;

  state_e            state_q, state_d;
  logic [1:0]        status_q, status_d;
  logic [1:0]        pstat_q, pstat_d;
  logic [WORD_W-1:0] epc_q, epc_d;
  logic [WORD_W-1:0] vec_q, vec_d;
  logic [WORD_W-1:0] code_q, code_d;

  logic ev_ok, exc, eret, irq_ev;
  logic trap, take, wr;

`ifdef CPU_CTRL_IRQ_EN
  logic [IRQ_W-1:0] sync_q, sync_d;
  logic [IRQ_W-1:0] pend_q, pend_d;
  logic [IRQ_W-1:0] mask_q, mask_d;
`else
  logic unused_irq;
  assign unused_irq = ^bus.IRQ;
`endif

  // Events only count in RUN on an unfrozen, valid MEM stage
  always_comb begin
    ev_ok  = (state_q == RUN) & bus.MEMEn
           & ~bus.MemBusy;
    exc    = ev_ok & (|bus.MEMExpCode);
    eret   = ev_ok & ~exc
           & (bus.MEMCtrlOp == 2'd2);
    irq_ev = 1'b0;
`ifdef CPU_CTRL_IRQ_EN
    irq_ev = ev_ok & ~exc & ~eret
           & status_q[1]
           & (|(pend_q & ~mask_q));
`endif
    trap   = exc | irq_ev;
    take   = trap | eret;
    wr     = bus.MEMEn & ~take
           & (bus.MEMCtrlOp == 2'd1);
  end

  always_comb begin
    bus.IFStall  = bus.MemBusy | bus.LDHazard
                 | bus.IFBusy;
    bus.IDStall  = bus.MemBusy | bus.LDHazard;
    bus.EXStall  = bus.MemBusy;
    bus.MEMStall = bus.MemBusy;
    bus.IFFlush  = 1'b0;
    // Bubble into EX on load-use, into ID on fetch miss
    bus.IDFlush  = ~bus.MemBusy
                 & (bus.LDHazard | bus.IFBusy);
    bus.EXFlush  = 1'b0;
    bus.MEMFlush = 1'b0;
    bus.NewPC    = vec_q[ADDR_W+1:2];
    if (eret) bus.NewPC = epc_q[ADDR_W-1:0];
    if (take) begin
      bus.IFStall  = 1'b0;
      bus.IDStall  = 1'b0;
      bus.EXStall  = 1'b0;
      bus.MEMStall = 1'b0;
      bus.IFFlush  = 1'b1;
      bus.IDFlush  = 1'b1;
      bus.EXFlush  = 1'b1;
      bus.MEMFlush = 1'b1;
    end
  end

  always_comb begin
    bus.CRegRdData = '0;
    case (bus.CRegRdAddr)
      5'd0: bus.CRegRdData = WORD_W'(status_q);
      5'd1: bus.CRegRdData = WORD_W'(pstat_q);
      5'd2: bus.CRegRdData = epc_q;
      5'd3: bus.CRegRdData = vec_q;
      5'd4: bus.CRegRdData = code_q;
`ifdef CPU_CTRL_IRQ_EN
      5'd5: bus.CRegRdData = WORD_W'(mask_q);
      5'd6: bus.CRegRdData = WORD_W'(pend_q);
`endif
      default: bus.CRegRdData = '0;
    endcase
  end

  assign bus.ExeMode = status_q[0];

  always_comb begin
    state_d  = take ? REDIR : RUN;
    status_d = status_q;
    pstat_d  = pstat_q;
    epc_d    = epc_q;
    vec_d    = vec_q;
    code_d   = code_q;
`ifdef CPU_CTRL_IRQ_EN
    sync_d   = bus.IRQ;
    pend_d   = sync_q;
    mask_d   = mask_q;
`endif
    if (wr) begin
      case (bus.MEMDstAddr)
        5'd0: status_d = bus.MEMWrData[1:0];
        5'd1: pstat_d  = bus.MEMWrData[1:0];
        5'd2: epc_d    = bus.MEMWrData;
        5'd3: vec_d    = bus.MEMWrData;
        5'd4: code_d   = bus.MEMWrData;
`ifdef CPU_CTRL_IRQ_EN
        5'd5: mask_d   = bus.MEMWrData[IRQ_W-1:0];
`endif
        default: ;
      endcase
    end
    if (trap) begin
      pstat_d  = status_q;
      status_d = 2'b00;
      epc_d    = WORD_W'(bus.MEMPC);
      code_d   = exc ? WORD_W'(bus.MEMExpCode)
                     : WORD_W'(1);
    end
    if (eret) status_d = pstat_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      status_q <= '0;
      pstat_q  <= '0;
      epc_q    <= '0;
      vec_q    <= '0;
      code_q   <= '0;
`ifdef CPU_CTRL_IRQ_EN
      sync_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '1;
`endif
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      pstat_q  <= pstat_d;
      epc_q    <= epc_d;
      vec_q    <= vec_d;
      code_q   <= code_d;
`ifdef CPU_CTRL_IRQ_EN
      sync_q   <= sync_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
`endif
    end
  end
endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// Directed bench for cpu_pipeline_ctrl: stalls, flushes, traps,
// EXRT, busy-held events, IRQ path and reset.
module tb_cpu_pipeline_ctrl;
  logic clk = 1'b0;
  logic reset;
  int n_run  = 0;
  int n_fail = 0;

  cpu_pipeline_ctrl_if bus ();

  cpu_pipeline_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] sf;
  assign sf = {bus.IFStall, bus.IDStall,
               bus.EXStall, bus.MEMStall,
               bus.IFFlush, bus.IDFlush,
               bus.EXFlush, bus.MEMFlush};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.IFBusy     = 1'b0;
    bus.MemBusy    = 1'b0;
    bus.LDHazard   = 1'b0;
    bus.MEMEn      = 1'b0;
    bus.MEMPC      = '0;
    bus.MEMExpCode = '0;
    bus.MEMCtrlOp  = '0;
    bus.MEMDstAddr = '0;
    bus.MEMWrData  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag,
                    input logic [4:0] a,
                    input logic [31:0] exp);
    bus.CRegRdAddr = a;
    #1;
    chk(tag, bus.CRegRdData, exp);
  endtask

  task automatic wrcr(input logic [4:0] a,
                      input logic [31:0] d);
    bus.MEMEn      = 1'b1;
    bus.MEMCtrlOp  = 2'd1;
    bus.MEMDstAddr = a;
    bus.MEMWrData  = d;
    step();
    idle();
  endtask

  task automatic mem_exc(input logic [2:0] c,
                         input logic [29:0] pc);
    bus.MEMEn      = 1'b1;
    bus.MEMExpCode = c;
    bus.MEMPC      = pc;
  endtask

  initial begin
    idle();
    bus.CRegRdAddr = '0;
    bus.IRQ        = 8'hFF;
    reset          = 1'b1;
    step();
    step();
    // 1: reset state
    chk("rst_mode", 32'(bus.ExeMode), 0);
    rd("rst_cr0", 0, 0);
`ifdef CPU_CTRL_IRQ_EN
    rd("rst_cr5", 5, 32'hFF);
`else
    rd("rst_cr5", 5, 0);
`endif
    chk("rst_sf", 32'(sf), 0);
    reset   = 1'b0;
    bus.IRQ = '0;
    step();

    // 2: exception redirect
    wrcr(0, 32'h2);
    bus.MEMEn      = 1'b1;
    bus.MEMCtrlOp  = 2'd1;
    bus.MEMDstAddr = 5'd3;
    bus.MEMWrData  = 32'h100;
    rd("nobypass", 3, 0);
    step();
    idle();
    rd("cr3_wr", 3, 32'h100);
    mem_exc(3'd2, 30'h40);
    #1;
    chk("exc_sf", 32'(sf), 32'h0F);
    chk("exc_pc", 32'(bus.NewPC), 32'h40);
    step();
    chk("redir_sf", 32'(sf), 0);
    rd("exc_cr2", 2, 32'h40);
    rd("exc_cr4", 4, 2);
    rd("exc_cr1", 1, 2);
    rd("exc_cr0", 0, 0);
    idle();
    step();

    // 3: trap from user mode then EXRT
    wrcr(0, 32'h3);
    chk("usr_mode", 32'(bus.ExeMode), 1);
    mem_exc(3'd3, 30'h55);
    #1;
    chk("t3_sf", 32'(sf), 32'h0F);
    step();
    idle();
    #1;
    chk("t3_kmode", 32'(bus.ExeMode), 0);
    rd("t3_cr1", 1, 3);
    rd("t3_cr2", 2, 32'h55);
    step();
    bus.MEMEn     = 1'b1;
    bus.MEMCtrlOp = 2'd2;
    #1;
    chk("exrt_sf", 32'(sf), 32'h0F);
    chk("exrt_pc", 32'(bus.NewPC), 32'h55);
    step();
    idle();
    #1;
    chk("exrt_mode", 32'(bus.ExeMode), 1);
    rd("exrt_cr0", 0, 3);
    step();

    // 4: event held while MEM is busy
    mem_exc(3'd5, 30'h77);
    bus.MemBusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_sf", 32'(sf), 32'hF0);
      step();
    end
    bus.MemBusy = 1'b0;
    #1;
    chk("rel_sf", 32'(sf), 32'h0F);
    chk("rel_pc", 32'(bus.NewPC), 32'h40);
    step();
    idle();
    rd("rel_cr4", 4, 5);
    rd("rel_cr2", 2, 32'h77);
    step();

    // 5: interrupt path
`ifdef CPU_CTRL_IRQ_EN
    wrcr(5, 32'hFB);
    wrcr(0, 32'h2);
    bus.IRQ   = 8'h04;
    bus.MEMEn = 1'b1;
    #1;
    chk("irq_c0", 32'(sf), 0);
    step();
    chk("irq_c1", 32'(sf), 0);
    step();
    chk("irq_c2", 32'(sf), 32'h0F);
    chk("irq_pc", 32'(bus.NewPC), 32'h40);
    step();
    idle();
    rd("irq_cr4", 4, 1);
    rd("irq_cr6", 6, 32'h04);
    rd("irq_cr1", 1, 2);
    step();
    wrcr(5, 32'hFF);
    wrcr(0, 32'h2);
    bus.MEMEn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("irq_msk", 32'(sf), 0);
      step();
    end
    idle();
    bus.IRQ = '0;
    step();
    step();
    step();
    rd("irq_drop", 6, 0);
`else
    wrcr(5, 32'hFB);
    rd("noirq_cr5", 5, 0);
    wrcr(0, 32'h2);
    bus.IRQ   = 8'h04;
    bus.MEMEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("noirq_sf", 32'(sf), 0);
      step();
    end
    rd("noirq_cr6", 6, 0);
    idle();
    bus.IRQ = '0;
    step();
`endif

    // 6: hazard stalls, take vs hazard, REDIR ignore
    bus.LDHazard = 1'b1;
    #1;
    chk("ld_sf", 32'(sf), 32'hC4);
    bus.LDHazard = 1'b0;
    bus.IFBusy   = 1'b1;
    #1;
    chk("ifb_sf", 32'(sf), 32'h84);
    bus.IFBusy   = 1'b0;
    bus.LDHazard = 1'b1;
    bus.MemBusy  = 1'b1;
    #1;
    chk("ldmb_sf", 32'(sf), 32'hF0);
    bus.MemBusy = 1'b0;
    mem_exc(3'd1, 30'h12);
    #1;
    chk("take_ld", 32'(sf), 32'h0F);
    step();
    chk("redir_ld", 32'(sf), 32'hC4);
    idle();
    step();

    // CR7 and CR6 writes
    wrcr(7, 32'hDEAD);
    rd("cr7", 7, 0);
    wrcr(6, 32'h55);
    rd("cr6_ro", 6, 0);

    // Mid-operation reset
    wrcr(0, 32'h3);
    chk("pre_rst", 32'(bus.ExeMode), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_mode", 32'(bus.ExeMode), 0);
    rd("mrst_cr3", 3, 0);
    rd("mrst_cr2", 2, 0);
    chk("mrst_sf", 32'(sf), 0);
    step();
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end
endmodule
